// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter: the boot loader and the CPU share one synchronous RAM.
// Each access runs IDLE -> ACCESS -> RESP; boot locks the CPU out, otherwise ties go round-robin.
module ram_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ce,
   input  logic              boot,
   input  logic              bl_req,
   input  logic              bl_rw,
   input  logic [ADDR_W-1:0] bl_adr,
   input  logic [DATA_W-1:0] bl_wdata,
   output logic              bl_ack,
   output logic [DATA_W-1:0] bl_rdata,
   input  logic              cpu_req,
   input  logic              cpu_rw,
   input  logic [ADDR_W-1:0] cpu_adr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              ram_enable,
   output logic              ram_rw,
   output logic [ADDR_W-1:0] ram_adr,
   output logic [DATA_W-1:0] ram_in,
   input  logic [DATA_W-1:0] ram_out,
   output logic [1:0]        owner,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic [1:0] OWN_NONE = 2'b00;
   localparam logic [1:0] OWN_BL   = 2'b01;
   localparam logic [1:0] OWN_CPU  = 2'b10;

   state_t              state_q, state_d;
   logic [1:0]          owner_q, owner_d;
   logic                last_cpu_q, last_cpu_d;
   logic                rw_q, rw_d;
   logic [ADDR_W-1:0]   adr_q, adr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   bl_rdata_q, bl_rdata_d;
   logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;

   logic bl_elig, cpu_elig, grant_bl, grant_cpu;

   // last_cpu_q = 1 means the CPU won the last contested grant, so the boot loader wins the next tie.
   assign bl_elig   = bl_req;
   assign cpu_elig  = cpu_req & ~boot;
   assign grant_bl  = bl_elig & (~cpu_elig | last_cpu_q);
   assign grant_cpu = cpu_elig & (~bl_elig | ~last_cpu_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         owner_q     <= OWN_NONE;
         last_cpu_q  <= 1'b1;
         rw_q        <= 1'b0;
         adr_q       <= '0;
         wdata_q     <= '0;
         bl_rdata_q  <= '0;
         cpu_rdata_q <= '0;
      end else if (ce) begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         last_cpu_q  <= last_cpu_d;
         rw_q        <= rw_d;
         adr_q       <= adr_d;
         wdata_q     <= wdata_d;
         bl_rdata_q  <= bl_rdata_d;
         cpu_rdata_q <= cpu_rdata_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      last_cpu_d  = last_cpu_q;
      rw_d        = rw_q;
      adr_d       = adr_q;
      wdata_d     = wdata_q;
      bl_rdata_d  = bl_rdata_q;
      cpu_rdata_d = cpu_rdata_q;
      case (state_q)
         IDLE: begin
            if (grant_bl) begin
               owner_d = OWN_BL;
               rw_d    = bl_rw;
               adr_d   = bl_adr;
               wdata_d = bl_wdata;
               state_d = ACCESS;
               if (cpu_elig) last_cpu_d = 1'b0;
            end else if (grant_cpu) begin
               owner_d = OWN_CPU;
               rw_d    = cpu_rw;
               adr_d   = cpu_adr;
               wdata_d = cpu_wdata;
               state_d = ACCESS;
               if (bl_elig) last_cpu_d = 1'b1;
            end
         end
         ACCESS: state_d = RESP;
         RESP: begin
            if (!rw_q) begin
               if (owner_q == OWN_BL) bl_rdata_d = ram_out;
               else if (owner_q == OWN_CPU) cpu_rdata_d = ram_out;
            end
            owner_d = OWN_NONE;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign ram_enable = ce & (state_q == ACCESS);
   assign bl_ack     = ce & (state_q == RESP) & (owner_q == OWN_BL);
   assign cpu_ack    = ce & (state_q == RESP) & (owner_q == OWN_CPU);

   // RAM data only arrives in RESP, so it is forwarded alongside ack and then held by the register.
   assign bl_rdata  = ((state_q == RESP) && (owner_q == OWN_BL) && !rw_q) ? ram_out : bl_rdata_q;
   assign cpu_rdata = ((state_q == RESP) && (owner_q == OWN_CPU) && !rw_q) ? ram_out : cpu_rdata_q;

   assign ram_rw    = rw_q;
   assign ram_adr   = adr_q;
   assign ram_in    = wdata_q;
   assign owner     = owner_q;
   assign dbg_state = state_q;

endmodule
